// File: rtl/spi_pkg.sv
// Shared definitions for the mode-3 SPI responder: frame width, FSM states
// and the SCLK idle level.
package spi_pkg;

    localparam int SPI_FRAME_W = 16;
    localparam int SPI_CNT_W   = 5;

    // Mode 3: SCLK rests high between frames.
    localparam logic SCLK_IDLE = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slv_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for a single asynchronous input, with a
// configurable reset level so idle-high lines do not glitch out of reset.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// 16-bit mode-3 SPI responder: captures one command per frame and shifts a
// preloaded response out on MISO. Define SPI_SLAVE_FRM_ERR_EN for frm_err.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [15:0] resp,
    input  logic        resp_ld,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        frm_err
);

    localparam logic [SPI_CNT_W-1:0] CNT_FULL = SPI_CNT_W'(SPI_FRAME_W);

    logic ss_n_s, sclk_s, mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .d(SS_n), .q(ss_n_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(SCLK), .q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(MOSI), .q(mosi_s)
    );

    spi_slv_state_t          state_q, state_d;
    logic                    ss_n_dly_q, sclk_dly_q, mosi_dly_q;
    logic [SPI_FRAME_W-1:0]  shft_reg_q, shft_reg_d;
    logic [SPI_FRAME_W-1:0]  resp_buf_q, resp_buf_d;
    logic [SPI_FRAME_W-1:0]  cmd_q, cmd_d;
    logic [SPI_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                    mosi_smpl_q, mosi_smpl_d;
    logic                    cmd_rdy_q, cmd_rdy_d;
    logic [SPI_FRAME_W-1:0]  resp_src;
    logic                    ss_fall, ss_rise, sclk_rise, sclk_fall;
`ifdef SPI_SLAVE_FRM_ERR_EN
    logic                    frm_err_q, frm_err_d;
`endif

    assign ss_fall   = ~ss_n_s &  ss_n_dly_q;
    assign ss_rise   =  ss_n_s & ~ss_n_dly_q;
    assign sclk_rise =  sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s &  sclk_dly_q;

    // A load coinciding with the frame start must reach the shifter directly.
    assign resp_src = resp_ld ? resp : resp_buf_q;

    always_comb begin
        state_d     = state_q;
        shft_reg_d  = shft_reg_q;
        resp_buf_d  = resp_ld ? resp : resp_buf_q;
        cmd_d       = cmd_q;
        bit_cnt_d   = bit_cnt_q;
        mosi_smpl_d = mosi_smpl_q;
        cmd_rdy_d   = cmd_rdy_q & ~clr_cmd_rdy;
`ifdef SPI_SLAVE_FRM_ERR_EN
        frm_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d    = ACTIVE;
                    shft_reg_d = resp_src;
                    bit_cnt_d  = '0;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    if (bit_cnt_q == CNT_FULL) begin
                        cmd_d     = {shft_reg_q[SPI_FRAME_W-2:0], mosi_smpl_q};
                        cmd_rdy_d = 1'b1;
                    end else begin
`ifdef SPI_SLAVE_FRM_ERR_EN
                        frm_err_d  = 1'b1;
                        shft_reg_d = resp_src;
`endif
                    end
                end else begin
                    if (sclk_rise) begin
                        mosi_smpl_d = mosi_dly_q;
                        if (bit_cnt_q != CNT_FULL) begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    // The fall at count 0 is the master's lead-in edge.
                    if (sclk_fall && (bit_cnt_q != '0) && (bit_cnt_q < CNT_FULL)) begin
                        shft_reg_d = {shft_reg_q[SPI_FRAME_W-2:0], mosi_smpl_q};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ss_n_dly_q  <= 1'b1;
            sclk_dly_q  <= SCLK_IDLE;
            mosi_dly_q  <= 1'b0;
            shft_reg_q  <= '0;
            resp_buf_q  <= '0;
            cmd_q       <= '0;
            bit_cnt_q   <= '0;
            mosi_smpl_q <= 1'b0;
            cmd_rdy_q   <= 1'b0;
`ifdef SPI_SLAVE_FRM_ERR_EN
            frm_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ss_n_dly_q  <= ss_n_s;
            sclk_dly_q  <= sclk_s;
            mosi_dly_q  <= mosi_s;
            shft_reg_q  <= shft_reg_d;
            resp_buf_q  <= resp_buf_d;
            cmd_q       <= cmd_d;
            bit_cnt_q   <= bit_cnt_d;
            mosi_smpl_q <= mosi_smpl_d;
            cmd_rdy_q   <= cmd_rdy_d;
`ifdef SPI_SLAVE_FRM_ERR_EN
            frm_err_q   <= frm_err_d;
`endif
        end
    end

    assign MISO    = shft_reg_q[SPI_FRAME_W-1];
    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
`ifdef SPI_SLAVE_FRM_ERR_EN
    assign frm_err = frm_err_q;
`else
    assign frm_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-3 master with 8 clk per SCLK phase, a vector
// table, hand-written corner sequences and a randomized frame model.
module tb_spi_slave;

    localparam int SYNC = 2;
`ifdef SPI_SLAVE_FRM_ERR_EN
    localparam int FRM_EN = 1;
`else
    localparam int FRM_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, SS_n, SCLK, MOSI, MISO;
    logic [15:0] resp, cmd;
    logic        resp_ld, cmd_rdy, clr_cmd_rdy, frm_err;

    int n_vec = 0;
    int n_err = 0;
    int frm_cnt = 0;

    spi_slave #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .resp(resp), .resp_ld(resp_ld), .cmd(cmd),
        .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frm_err === 1'b1) frm_cnt <= frm_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ld;
        logic [15:0] resp;
        logic [15:0] tx;
        logic        clr;
        logic [15:0] exp_cmd;
        logic        exp_rdy;
        logic [15:0] exp_rx;
    } vec_t;

    vec_t vecs[6];

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_resp(input logic [15:0] v);
        resp = v; resp_ld = 1'b1;
        wclk(1);
        resp_ld = 1'b0;
        wclk(1);
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        wclk(1);
        clr_cmd_rdy = 1'b0;
        wclk(3);
    endtask

    // Even edge index = falling edge (launch MOSI), odd = rising (sample MISO).
    task automatic spi_xfer(input logic [15:0] tx, input int nedges, input bit release_ss,
                            input int ld_edge, input logic [15:0] ld_val,
                            output logic [15:0] rx);
        rx = '0;
        SS_n = 1'b0;
        wclk(8);
        for (int e = 0; e < nedges; e++) begin
            if (e % 2 == 0) begin
                SCLK = 1'b0;
                MOSI = tx[15 - e/2];
            end else begin
                SCLK = 1'b1;
                rx[15 - e/2] = MISO;
            end
            if (e == ld_edge) begin
                resp = ld_val; resp_ld = 1'b1;
                wclk(1);
                resp_ld = 1'b0;
                wclk(7);
            end else begin
                wclk(8);
            end
        end
        if (release_ss) begin
            SS_n = 1'b1;
            wclk(1);
            SCLK = 1'b1;
            wclk(10);
        end
    endtask

    logic [15:0] rx, cmd_m, resp_m, tx_r, r_r;
    logic        rdy_m;
    int          fb, ne;
    bit          ld_r;

    initial begin
        vecs[0] = '{1'b1, 16'hA5C3, 16'h1234, 1'b0, 16'h1234, 1'b1, 16'hA5C3};
        vecs[1] = '{1'b1, 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 1'b1, 16'h0000};
        vecs[2] = '{1'b0, 16'h0000, 16'h0001, 1'b1, 16'h0001, 1'b1, 16'h0000};
        vecs[3] = '{1'b1, 16'h8001, 16'h7FFE, 1'b0, 16'h7FFE, 1'b1, 16'h8001};
        vecs[4] = '{1'b0, 16'h0000, 16'hC33C, 1'b1, 16'hC33C, 1'b1, 16'h8001};
        vecs[5] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'hFFFF};

        rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        resp = '0; resp_ld = 1'b0; clr_cmd_rdy = 1'b0;
        wclk(3);
        rst_n = 1'b1;
        wclk(10);
        check("reset_miso", 32'(MISO), 32'h0);
        check("reset_cmd", 32'(cmd), 32'h0);
        check("reset_rdy", 32'(cmd_rdy), 32'h0);
        check("reset_frm_err", 32'(frm_cnt), 32'h0);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].ld) load_resp(vecs[i].resp);
            spi_xfer(vecs[i].tx, 32, 1'b1, -1, 16'h0, rx);
            check($sformatf("vec%0d_rx", i), 32'(rx), 32'(vecs[i].exp_rx));
            check($sformatf("vec%0d_cmd", i), 32'(cmd), 32'(vecs[i].exp_cmd));
            check($sformatf("vec%0d_rdy", i), 32'(cmd_rdy), 32'(vecs[i].exp_rdy));
            if (vecs[i].clr) begin
                pulse_clr();
                check($sformatf("vec%0d_rdy_clr", i), 32'(cmd_rdy), 32'h0);
            end
        end

        // Response reload mid-frame only affects the following frame.
        load_resp(16'h1111);
        spi_xfer(16'h2222, 32, 1'b1, 11, 16'h0F0F, rx);
        check("midld_rx_cur", 32'(rx), 32'h1111);
        check("midld_cmd_cur", 32'(cmd), 32'h2222);
        spi_xfer(16'h3333, 32, 1'b1, -1, 16'h0, rx);
        check("midld_rx_next", 32'(rx), 32'h0F0F);
        check("midld_cmd_next", 32'(cmd), 32'h3333);

        // Aborted frame after 9 edges, then a clean frame.
        pulse_clr();
        fb = frm_cnt;
        spi_xfer(16'hABCD, 9, 1'b1, -1, 16'h0, rx);
        check("short_cmd", 32'(cmd), 32'h3333);
        check("short_rdy", 32'(cmd_rdy), 32'h0);
        check("short_frm_err", 32'(frm_cnt - fb), 32'(FRM_EN));
        spi_xfer(16'hBEEF, 32, 1'b1, -1, 16'h0, rx);
        check("after_short_cmd", 32'(cmd), 32'hBEEF);
        check("after_short_rdy", 32'(cmd_rdy), 32'h1);
        check("after_short_rx", 32'(rx), 32'h0F0F);

        // Reset asserted after 6 bits of a frame.
        load_resp(16'hC0DE);
        spi_xfer(16'h5555, 12, 1'b0, -1, 16'h0, rx);
        rst_n = 1'b0;
        SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        wclk(3);
        check("midrst_miso", 32'(MISO), 32'h0);
        check("midrst_cmd", 32'(cmd), 32'h0);
        check("midrst_rdy", 32'(cmd_rdy), 32'h0);
        check("midrst_frm_err", 32'(frm_err), 32'h0);
        rst_n = 1'b1;
        wclk(5);
        spi_xfer(16'h8001, 32, 1'b1, -1, 16'h0, rx);
        check("postrst_cmd", 32'(cmd), 32'h8001);
        check("postrst_rdy", 32'(cmd_rdy), 32'h1);
        check("postrst_rx", 32'(rx), 32'h0000);

        // Randomized frames against a frame-level model.
        resp_m = 16'h0000; cmd_m = 16'h8001; rdy_m = 1'b1;
        for (int k = 0; k < 24; k++) begin
            ld_r = ($urandom_range(0, 2) == 0);
            r_r  = 16'($urandom);
            if (ld_r) begin
                load_resp(r_r);
                resp_m = r_r;
            end
            ne   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : 32;
            tx_r = 16'($urandom);
            fb   = frm_cnt;
            spi_xfer(tx_r, ne, 1'b1, -1, 16'h0, rx);
            if (ne == 32) begin
                cmd_m = tx_r;
                rdy_m = 1'b1;
                check($sformatf("rnd%0d_rx", k), 32'(rx), 32'(resp_m));
            end
            check($sformatf("rnd%0d_cmd", k), 32'(cmd), 32'(cmd_m));
            check($sformatf("rnd%0d_rdy", k), 32'(cmd_rdy), 32'(rdy_m));
            check($sformatf("rnd%0d_frm_err", k), 32'(frm_cnt - fb),
                  32'((ne != 32) ? FRM_EN : 0));
            if ($urandom_range(0, 2) == 0) begin
                pulse_clr();
                rdy_m = 1'b0;
                check($sformatf("rnd%0d_rdy_clr", k), 32'(cmd_rdy), 32'(rdy_m));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
